// File: rtl/pipe_pkg.sv
// Shared widths, control-bit positions and payload sizing for the pipeline stage register.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int WN_W_DEF   = 5;

    // Bit positions inside the control vector carried by each beat.
    localparam int CTRL_MEMTOREG = 0;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_SHIFT    = 2;

    // Width of one packed beat: {data fields, write number, control}.
    function automatic int payload_w(input int n_data, input int data_w,
                                     input int wn_w, input int ctrl_w);
        return n_data * data_w + wn_w + ctrl_w;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: a valid bit plus a packed payload {data, wn, ctrl}.
// Control sits in the low CTRL_W bits so it can be zeroed on its own.
module pipe_slot #(
    parameter int PAYLOAD_W = 40,
    parameter int CTRL_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    input  logic                 clear,
    input  logic                 clear_ctrl,
    input  logic                 clear_data,
    input  logic [PAYLOAD_W-1:0] d,
    output logic                 v,
    output logic [PAYLOAD_W-1:0] q
);

    // Reset wins, a low enable freezes the slot, load beats the clear terms.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v <= 1'b0;
            q <= '0;
        end else if (en) begin
            if (load) begin
                v <= 1'b1;
                q <= d;
            end else begin
                if (clear)
                    v <= 1'b0;
                if (clear_ctrl)
                    q[CTRL_W-1:0] <= '0;
                if (clear_data)
                    q[PAYLOAD_W-1:CTRL_W] <= '0;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between two stages: main slot drives the outputs,
// skid slot absorbs the one beat that arrives while the consumer stalls.
//
// Handshake: a beat moves when valid and ready are both high at a rising edge.
// in_ready depends only on registered state (never on in_valid); out_valid never
// waits for out_ready; en_reg=0 drops both valid and ready and freezes everything.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int N_DATA     = 3,
    parameter int WN_W       = WN_W_DEF,
    parameter int CTRL_W     = 3,
    parameter int FLUSH_DATA = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_reg,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_DATA*DATA_W-1:0] in_data,
    input  logic [WN_W-1:0]          in_wn,
    input  logic [CTRL_W-1:0]        in_ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_DATA*DATA_W-1:0] out_data,
    output logic [WN_W-1:0]          out_wn,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [1:0]               occupancy
);

    localparam int DATA_TW   = N_DATA * DATA_W;
    localparam int PAYLOAD_W = payload_w(N_DATA, DATA_W, WN_W, CTRL_W);

    logic                 main_v, skid_v;
    logic [PAYLOAD_W-1:0] main_q, skid_q, main_d, in_payload;
    logic                 in_fire, out_fire;
    logic                 main_load, main_clear, skid_load, skid_clear;
    logic                 clr_ctrl, clr_data;

    assign in_payload = {in_data, in_wn, in_ctrl};
    assign in_ready   = en_reg & ~skid_v;
    assign out_valid  = en_reg & main_v;
    assign in_fire    = in_valid & in_ready & ~flush;
    assign out_fire   = out_valid & out_ready;

    // Steering: decide which slot loads, from where, and which slots empty.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d     = in_payload;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        clr_ctrl   = 1'b0;
        clr_data   = 1'b0;
        if (flush) begin
            // Kill everything held; a beat taken downstream this cycle is already gone.
            main_clear = 1'b1;
            skid_clear = 1'b1;
            clr_ctrl   = 1'b1;
            clr_data   = (FLUSH_DATA != 0);
        end else if (skid_v) begin
            // Skid full means in_ready was low, so only the skid->main move is possible.
            if (out_fire) begin
                main_load  = 1'b1;
                main_d     = skid_q;
                skid_clear = 1'b1;
            end
        end else if (main_v) begin
            if (out_fire) begin
                if (in_fire)
                    main_load = 1'b1;
                else
                    main_clear = 1'b1;
            end else if (in_fire) begin
                skid_load = 1'b1;
            end
        end else if (in_fire) begin
            main_load = 1'b1;
        end
    end

    pipe_slot #(.PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W)) u_main (
        .clk        (clk),
        .rst        (rst),
        .en         (en_reg),
        .load       (main_load),
        .clear      (main_clear),
        .clear_ctrl (clr_ctrl),
        .clear_data (clr_data),
        .d          (main_d),
        .v          (main_v),
        .q          (main_q)
    );

    pipe_slot #(.PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .en         (en_reg),
        .load       (skid_load),
        .clear      (skid_clear),
        .clear_ctrl (clr_ctrl),
        .clear_data (clr_data),
        .d          (in_payload),
        .v          (skid_v),
        .q          (skid_q)
    );

    assign out_data  = main_q[PAYLOAD_W-1 -: DATA_TW];
    assign out_wn    = main_q[CTRL_W +: WN_W];
    // A bubble must never present live control bits (e.g. RegWrite).
    assign out_ctrl  = out_valid ? main_q[CTRL_W-1:0] : '0;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default-parameter instance checked through
// an expected-beat queue, plus a wide/flush-clearing instance checked directly.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int ND = 3;
    localparam int WW = 5;
    localparam int CW = 3;
    localparam int PW = ND * DW + WW + CW;

    localparam int DW2 = 16;
    localparam int ND2 = 4;

    logic clk;
    logic rst;

    logic           en_reg, flush, in_valid, in_ready, out_valid, out_ready;
    logic [ND*DW-1:0] in_data, out_data;
    logic [WW-1:0]  in_wn, out_wn;
    logic [CW-1:0]  in_ctrl, out_ctrl;
    logic [1:0]     occupancy;

    logic             b_en, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [ND2*DW2-1:0] b_in_data, b_out_data;
    logic [WW-1:0]    b_in_wn, b_out_wn;
    logic [CW-1:0]    b_in_ctrl, b_out_ctrl;
    logic [1:0]       b_occ;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] mon_exp, mon_got;
    int total = 0;
    int bad   = 0;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .en_reg(en_reg), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_wn(in_wn), .in_ctrl(in_ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_wn(out_wn),
        .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    pipe_stage_reg #(.DATA_W(DW2), .N_DATA(ND2), .FLUSH_DATA(1)) dut_b (
        .clk(clk), .rst(rst), .en_reg(b_en), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_wn(b_in_wn), .in_ctrl(b_in_ctrl), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_wn(b_out_wn),
        .out_ctrl(b_out_ctrl), .occupancy(b_occ)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every field k of a beat carries base + k*256, so packing errors show up.
    function automatic logic [ND*DW-1:0] make_data(input int base);
        logic [ND*DW-1:0] r;
        for (int k = 0; k < ND; k++)
            r[k*DW +: DW] = DW'(base + k * 256);
        return r;
    endfunction

    // Offer one beat for the coming edge; optionally record it as expected output.
    task automatic offer(input int base, input logic [WW-1:0] wn, input logic [CW-1:0] ctrl,
                         input bit expect_out);
        in_valid = 1'b1;
        in_data  = make_data(base);
        in_wn    = wn;
        in_ctrl  = ctrl;
        if (expect_out)
            exp_q.push_back({make_data(base), wn, ctrl});
    endtask

    // Scoreboard monitor: every delivered beat must match the head of the queue.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            total++;
            mon_got = {out_data, out_wn, out_ctrl};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: got %0h, queue empty", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL beat_payload: got %0h expected %0h", mon_got, mon_exp);
                end
            end
        end
    end

    // A skid beat without a main beat would break ordering.
    always @(negedge clk) begin
        if (rst) begin
            assert (!(dut.skid_v && !dut.main_v))
            else begin
                bad++;
                $display("FAIL skid_without_main: skid_v=1 main_v=0");
            end
        end
    end

    initial begin
        rst = 1'b0; en_reg = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = make_data(8'h5A); in_wn = 5'd9; in_ctrl = 3'b111;
        b_en = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_data = '0; b_in_wn = '0; b_in_ctrl = '0;

        // Reset with a live offer present
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_wn", out_wn, 0);
        rst = 1'b1; in_valid = 1'b0;
        check("rst_in_ready", in_ready, 1);

        // Streaming: one beat per cycle, visible one cycle after acceptance
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("stream_in_ready", in_ready, 1);
            offer(8'hA0 + i, 5'(i), 3'(i), 1'b1);
            tick();
            check("stream_out_valid", out_valid, 1);
            check("stream_out_field0", out_data[DW-1:0], 32'hA0 + i);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_valid", out_valid, 0);
        check("stream_drain_occ", occupancy, 0);

        // Back-pressure: two beats fill main and skid, then drain in order
        out_ready = 1'b0;
        offer(8'h11, 5'd1, 3'b010, 1'b1);
        tick();
        check("bp_occ1", occupancy, 1);
        check("bp_in_ready1", in_ready, 1);
        offer(8'h22, 5'd2, 3'b001, 1'b1);
        tick();
        in_valid = 1'b0;
        check("bp_occ2", occupancy, 2);
        check("bp_in_ready0", in_ready, 0);
        check("bp_head", out_data[DW-1:0], 32'h11);
        check("bp_ctrl", out_ctrl, 3'b010);
        out_ready = 1'b1;
        tick();
        check("bp_after1_occ", occupancy, 1);
        check("bp_after1_data", out_data[DW-1:0], 32'h22);
        tick();
        check("bp_after2_occ", occupancy, 0);

        // Flush with a full skid and a fresh offer in the flush cycle
        out_ready = 1'b0;
        offer(8'h44, 5'd4, 3'b011, 1'b0);
        tick();
        offer(8'h55, 5'd5, 3'b011, 1'b0);
        tick();
        check("fl_pre_occ", occupancy, 2);
        offer(8'h33, 5'd3, 3'b010, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_occ", occupancy, 0);
        check("fl_out_valid", out_valid, 0);
        check("fl_out_ctrl", out_ctrl, 0);
        check("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("fl_no_emit_occ", occupancy, 0);

        // Hold: en_reg low freezes a held beat regardless of the handshakes
        out_ready = 1'b0;
        offer(8'h66, 5'd6, 3'b110, 1'b1);
        tick();
        check("hold_pre_occ", occupancy, 1);
        en_reg = 1'b0;
        in_data = make_data(8'h77);
        for (int c = 0; c < 5; c++) begin
            in_valid  = c[0];
            out_ready = ~c[0];
            flush     = (c == 2);
            #1;
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 0);
            check("hold_out_ctrl", out_ctrl, 0);
            tick();
            check("hold_occ", occupancy, 1);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; en_reg = 1'b1;
        #1;
        check("hold_resume_valid", out_valid, 1);
        check("hold_resume_data", out_data[DW-1:0], 32'h66);
        tick();
        check("hold_resume_occ", occupancy, 0);

        // Reset mid-transfer discards the held beat
        out_ready = 1'b0;
        offer(8'h88, 5'd8, 3'b111, 1'b0);
        tick();
        in_valid = 1'b0;
        check("mid_pre_occ", occupancy, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_occ", occupancy, 0);
        out_ready = 1'b1;
        tick(); tick();
        check("mid_no_emit", out_valid, 0);

        // Wide instance: field packing and flush clearing data/wn
        b_in_valid = 1'b1;
        b_in_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        b_in_wn    = 5'h1F;
        b_in_ctrl  = 3'b110;
        tick();
        b_in_valid = 1'b0;
        for (int k = 0; k < ND2; k++)
            check("b_field", b_out_data[k*DW2 +: DW2], 16'h1111 * (k + 1));
        check("b_wn", b_out_wn, 5'h1F);
        check("b_ctrl", b_out_ctrl, 3'b110);
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        check("b_fl_data", b_out_data, 0);
        check("b_fl_wn", b_out_wn, 0);
        check("b_fl_valid", b_out_valid, 0);
        check("b_fl_occ", b_occ, 0);

        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
